hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter: width, default 32, width of each perf counter output.
REQ-002 SHALL have port: clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: IF_ID_rs1_i, IF_ID_rs2_i  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports: IF_ID_uses_rs1_i, IF_ID_uses_rs2_i  input  1 each  ID instruction actually reads rs1/rs2.
REQ-006 SHALL have ports: ID_EX_rd_i  input  5  and  ID_EX_mem_read_i  input  1  destination of, and load flag for, the EX instruction.
REQ-007 SHALL have ports: imem_read_i, imem_resp_i  input  1 each  instruction-cache request/response.
REQ-008 SHALL have ports: dmem_read_i, dmem_write_i, dmem_resp_i  input  1 each  data-cache request from MEM/response.
REQ-009 SHALL have port: redirect_i  input  1  control-flow redirect resolved (mispredict/jump); younger instructions must be squashed.
REQ-010 SHALL have ports: PC_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o  output  1 each  stage register enables.
REQ-011 SHALL have ports: IF_ID_flush_o, ID_EX_flush_o  output  1 each  replace stage contents with a NOP bubble.
REQ-012 SHALL have ports: freeze_cnt_o, bubble_cnt_o, flush_cnt_o  output  width each  performance counters.

Function
REQ-013 SHALL compute mem_stall = (imem_read_i & ~imem_resp_i) | ((dmem_read_i | dmem_write_i) & ~dmem_resp_i).
REQ-014 SHALL compute load_use = ID_EX_mem_read_i & (ID_EX_rd_i != 0) & ((IF_ID_uses_rs1_i & rs1 == rd) | (IF_ID_uses_rs2_i & rs2 == rd)).
REQ-015 SHALL hold a state register with states RUN, FREEZE, FREEZE_FLUSH; FREEZE_FLUSH means a redirect is pending.
REQ-016 SHALL, when mem_stall=1 in any state: drive all five loads 0 and both flushes 0 in that same cycle.
REQ-017 SHALL, on a mem_stall cycle, transition to FREEZE_FLUSH if redirect_i=1 or state is FREEZE_FLUSH; otherwise to FREEZE.
REQ-018 SHALL, when mem_stall=0 and (redirect_i=1 or state=FREEZE_FLUSH): drive all loads 1, IF_ID_flush_o=1, ID_EX_flush_o=1; next state RUN.
REQ-019 SHALL, when mem_stall=0, no flush condition, and load_use=1: drive PC_load_o=0, IF_ID_load_o=0, ID_EX_flush_o=1, remaining loads 1, IF_ID_flush_o=0; next state RUN.
REQ-020 SHALL, otherwise, drive all loads 1 and both flushes 0; next state RUN.
REQ-021 SHALL apply priority: mem_stall > redirect (live or pending) > load_use.
REQ-022 SHALL ignore load_use in any cycle where a flush is applied (the dependent instruction is squashed).
REQ-023 SHALL produce all outputs combinationally from the inputs and current state, with zero-cycle latency and no added pipeline delay.
REQ-024 SHALL apply a pending redirect exactly once, on the first cycle mem_stall deasserts, even if redirect_i has since dropped.
REQ-025 SHALL treat a response arriving in the same cycle as its request as no stall.

Reset
REQ-026 SHALL, while rst_n=0, force state RUN, clear any pending flush, and zero all counters, independent of clk.
REQ-027 SHALL, while rst_n=0, drive combinational outputs per REQ-016..020 with state RUN.
REQ-028 SHALL, on reset asserted mid-freeze, discard the pending redirect.

Configuration
REQ-029 SHALL, with HAZARD_PERF_CNT_EN defined, increment freeze_cnt_o on each mem_stall cycle, bubble_cnt_o on each load-use bubble cycle, and flush_cnt_o on each flush cycle.
REQ-030 SHALL wrap each counter modulo 2^width.
REQ-031 SHALL, without HAZARD_PERF_CNT_EN, tie all three counter outputs to 0 and instantiate no counter registers.

Verification
REQ-032 SHALL cover: lw x5 in EX, ID reads x5 via rs2 -> exactly 1 cycle with PC_load=0, IF_ID_load=0, ID_EX_flush=1; bubble_cnt=1.
REQ-033 SHALL cover: lw x0 in EX, ID reads x0 -> no stall, all loads 1.
REQ-034 SHALL cover: dmem_read=1 with resp held low 4 cycles -> 4 cycles all loads 0; freeze_cnt=4; 5th cycle with resp=1 -> all loads 1.
REQ-035 SHALL cover: redirect_i=1 for 1 cycle during a 3-cycle imem freeze -> state FREEZE_FLUSH; first unfrozen cycle -> both flushes 1; flush_cnt=1.
REQ-036 SHALL cover: redirect_i=1 and load_use=1 with no stall -> both flushes 1, PC_load=1, bubble_cnt unchanged.
REQ-037 SHALL cover: rst_n low asynchronously mid-FREEZE_FLUSH, then released with no stall -> no flush issued, counters 0.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: freezes the pipeline on cache misses, squashes younger
// instructions on redirects (remembering a redirect that arrives while frozen), and
// inserts a one-cycle bubble on load-use dependencies.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined;
// otherwise the counter outputs are tied to zero and no counter flops exist.
module hazard_controller #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1_i,
    input  logic [4:0]       IF_ID_rs2_i,
    input  logic             IF_ID_uses_rs1_i,
    input  logic             IF_ID_uses_rs2_i,
    input  logic [4:0]       ID_EX_rd_i,
    input  logic             ID_EX_mem_read_i,
    input  logic             imem_read_i,
    input  logic             imem_resp_i,
    input  logic             dmem_read_i,
    input  logic             dmem_write_i,
    input  logic             dmem_resp_i,
    input  logic             redirect_i,
    output logic             PC_load_o,
    output logic             IF_ID_load_o,
    output logic             ID_EX_load_o,
    output logic             EX_MEM_load_o,
    output logic             MEM_WB_load_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic [width-1:0] freeze_cnt_o,
    output logic [width-1:0] bubble_cnt_o,
    output logic [width-1:0] flush_cnt_o
);

    // StFreezeFlush: frozen with a redirect still owed to the front end
    typedef enum logic [1:0] {StRun, StFreeze, StFreezeFlush} state_e;

    state_e state_q, state_d;
    logic   mem_stall;
    logic   load_use;
    logic   do_flush;
    logic   do_bubble;

    // Hazard detection; a response in the same cycle as its request is not a stall
    always_comb begin
        mem_stall = (imem_read_i & ~imem_resp_i) |
                    ((dmem_read_i | dmem_write_i) & ~dmem_resp_i);
        load_use  = ID_EX_mem_read_i & (ID_EX_rd_i != 5'd0) &
                    ((IF_ID_uses_rs1_i & (IF_ID_rs1_i == ID_EX_rd_i)) |
                     (IF_ID_uses_rs2_i & (IF_ID_rs2_i == ID_EX_rd_i)));
    end

    // Priority decode: stall > redirect (live or pending) > load-use bubble
    always_comb begin
        PC_load_o     = 1'b1;
        IF_ID_load_o  = 1'b1;
        ID_EX_load_o  = 1'b1;
        EX_MEM_load_o = 1'b1;
        MEM_WB_load_o = 1'b1;
        IF_ID_flush_o = 1'b0;
        ID_EX_flush_o = 1'b0;
        do_flush      = 1'b0;
        do_bubble     = 1'b0;
        state_d       = StRun;
        if (mem_stall) begin
            PC_load_o     = 1'b0;
            IF_ID_load_o  = 1'b0;
            ID_EX_load_o  = 1'b0;
            EX_MEM_load_o = 1'b0;
            MEM_WB_load_o = 1'b0;
            state_d       = (redirect_i || (state_q == StFreezeFlush)) ? StFreezeFlush
                                                                       : StFreeze;
        end else if (redirect_i || (state_q == StFreezeFlush)) begin
            // The dependent instruction is squashed, so load-use is irrelevant here
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
            do_flush      = 1'b1;
        end else if (load_use) begin
            PC_load_o     = 1'b0;
            IF_ID_load_o  = 1'b0;
            ID_EX_flush_o = 1'b1;
            do_bubble     = 1'b1;
        end
    end

    // State register; reset drops any pending redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [width-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [width-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [width-1:0] flush_cnt_q, flush_cnt_d;

    // Counter increments; wrap naturally modulo 2^width
    always_comb begin
        freeze_cnt_d = freeze_cnt_q + width'(mem_stall);
        bubble_cnt_d = bubble_cnt_q + width'(do_bubble);
        flush_cnt_d  = flush_cnt_q + width'(do_flush);
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze_cnt_q <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            freeze_cnt_q <= freeze_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign freeze_cnt_o = freeze_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`else
    assign freeze_cnt_o = '0;
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: the driver applies one directed vector per
// cycle and queues its hand-computed response; the monitor pops and compares on the
// falling edge. Counter expectations collapse to zero unless HAZARD_PERF_CNT_EN is set.
module tb_hazard_controller;

    localparam int unsigned W = 8;

    // Control outputs packed as {PC, IF_ID, ID_EX, EX_MEM, MEM_WB, IF_ID_flush, ID_EX_flush}
    localparam logic [6:0] NORM  = 7'b11111_00;
    localparam logic [6:0] STALL = 7'b00000_00;
    localparam logic [6:0] BUB   = 7'b00111_01;
    localparam logic [6:0] FLUSH = 7'b11111_11;

    typedef struct packed {
        logic [6:0]   ctrl;
        logic         chk_cnt;
        logic [W-1:0] fz;
        logic [W-1:0] bb;
        logic [W-1:0] fl;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   rs1, rs2, rd;
    logic         u1, u2, mr, imr, imresp, dmr, dmw, dmresp, redir;
    logic         pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_fl, idex_fl;
    logic [W-1:0] freeze_cnt, bubble_cnt, flush_cnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;

    always #5 clk = ~clk;

    hazard_controller #(.width(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IF_ID_rs1_i      (rs1),
        .IF_ID_rs2_i      (rs2),
        .IF_ID_uses_rs1_i (u1),
        .IF_ID_uses_rs2_i (u2),
        .ID_EX_rd_i       (rd),
        .ID_EX_mem_read_i (mr),
        .imem_read_i      (imr),
        .imem_resp_i      (imresp),
        .dmem_read_i      (dmr),
        .dmem_write_i     (dmw),
        .dmem_resp_i      (dmresp),
        .redirect_i       (redir),
        .PC_load_o        (pc_ld),
        .IF_ID_load_o     (ifid_ld),
        .ID_EX_load_o     (idex_ld),
        .EX_MEM_load_o    (exmem_ld),
        .MEM_WB_load_o    (memwb_ld),
        .IF_ID_flush_o    (ifid_fl),
        .ID_EX_flush_o    (idex_fl),
        .freeze_cnt_o     (freeze_cnt),
        .bubble_cnt_o     (bubble_cnt),
        .flush_cnt_o      (flush_cnt)
    );

    // Start a new cycle: step past the edge, then return inputs to idle
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; mr = 1'b0;
        imr = 1'b0; imresp = 1'b0;
        dmr = 1'b0; dmw = 1'b0; dmresp = 1'b0;
        redir = 1'b0;
    endtask

    // Queue the expected response for the vector just driven
    task automatic push(input logic [6:0] ctrl, input logic chk,
                        input int fz, input int bb, input int fl);
        exp_t e;
        e.ctrl    = ctrl;
        e.chk_cnt = chk;
`ifdef HAZARD_PERF_CNT_EN
        e.fz = W'(fz);
        e.bb = W'(bb);
        e.fl = W'(fl);
`else
        e.fz = '0;
        e.bb = '0;
        e.fl = '0;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: every falling edge with a queued expectation is one compared cycle
    initial begin
        exp_t        e;
        logic [6:0]  act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vec_id++;
                act = {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_fl, idex_fl};
                n_checks++;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl vec%0d: got %b expected %b", vec_id, act, e.ctrl);
                end
                if (e.chk_cnt) begin
                    n_checks++;
                    if ({freeze_cnt, bubble_cnt, flush_cnt} !== {e.fz, e.bb, e.fl}) begin
                        n_fail++;
                        $display("FAIL counters vec%0d: got f=%0d b=%0d fl=%0d expected f=%0d b=%0d fl=%0d",
                                 vec_id, freeze_cnt, bubble_cnt, flush_cnt, e.fz, e.bb, e.fl);
                    end
                end
            end
        end
    end

    // Driver: directed vectors with hand-computed responses
    initial begin
        rst_n = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; mr = 1'b0;
        imr = 1'b0; imresp = 1'b0; dmr = 1'b0; dmw = 1'b0; dmresp = 1'b0;
        redir = 1'b0;

        // Reset state
        next_cycle(); push(NORM, 1'b1, 0, 0, 0);
        next_cycle(); rst_n = 1'b1; push(NORM, 1'b1, 0, 0, 0);

        // lw x5 in EX, ID reads x5 via rs2: one bubble cycle
        next_cycle(); mr = 1; rd = 5'd5; u2 = 1; rs2 = 5'd5; u1 = 1; rs1 = 5'd3;
        push(BUB, 1'b1, 0, 0, 0);
        next_cycle(); push(NORM, 1'b1, 0, 1, 0);

        // lw x0: never a hazard
        next_cycle(); mr = 1; rd = 5'd0; u1 = 1; u2 = 1; push(NORM, 1'b0, 0, 0, 0);
        // rs1 matches but is not used
        next_cycle(); mr = 1; rd = 5'd7; rs1 = 5'd7; u2 = 1; rs2 = 5'd2;
        push(NORM, 1'b0, 0, 0, 0);
        // rs1 match, used
        next_cycle(); mr = 1; rd = 5'd7; rs1 = 5'd7; u1 = 1; push(BUB, 1'b0, 0, 0, 0);
        // Same registers but EX is not a load
        next_cycle(); rd = 5'd7; rs1 = 5'd7; u1 = 1; push(NORM, 1'b1, 0, 2, 0);

        // dmem read miss for 4 cycles, then response
        for (int i = 0; i < 4; i++) begin
            next_cycle(); dmr = 1; push(STALL, 1'b0, 0, 0, 0);
        end
        next_cycle(); dmr = 1; dmresp = 1; push(NORM, 1'b1, 4, 2, 0);

        // Store miss outranks a concurrent load-use
        next_cycle(); dmw = 1; mr = 1; rd = 5'd5; rs2 = 5'd5; u2 = 1;
        push(STALL, 1'b0, 0, 0, 0);
        // Same-cycle responses are not stalls
        next_cycle(); imr = 1; imresp = 1; dmr = 1; dmresp = 1; push(NORM, 1'b1, 5, 2, 0);

        // 3-cycle imem freeze with a 1-cycle redirect in the middle
        next_cycle(); imr = 1; push(STALL, 1'b0, 0, 0, 0);
        next_cycle(); imr = 1; redir = 1; push(STALL, 1'b0, 0, 0, 0);
        next_cycle(); imr = 1; push(STALL, 1'b0, 0, 0, 0);
        next_cycle(); push(FLUSH, 1'b1, 8, 2, 0);
        next_cycle(); push(NORM, 1'b1, 8, 2, 1);

        // Live redirect with load-use: flush wins, no bubble counted
        next_cycle(); redir = 1; mr = 1; rd = 5'd9; rs1 = 5'd9; u1 = 1;
        push(FLUSH, 1'b0, 0, 0, 0);
        next_cycle(); push(NORM, 1'b1, 8, 2, 2);

        // Pending redirect outranks load-use once the stall clears
        next_cycle(); dmr = 1; redir = 1; push(STALL, 1'b0, 0, 0, 0);
        next_cycle(); mr = 1; rd = 5'd4; rs2 = 5'd4; u2 = 1; push(FLUSH, 1'b0, 0, 0, 0);
        next_cycle(); push(NORM, 1'b1, 9, 2, 3);

        // Reset asserted mid freeze-with-pending-redirect
        next_cycle(); imr = 1; redir = 1; push(STALL, 1'b0, 0, 0, 0);
        next_cycle(); imr = 1; push(STALL, 1'b1, 10, 2, 3);
        next_cycle(); rst_n = 1'b0; push(NORM, 1'b1, 0, 0, 0);
        // Outputs stay combinational during reset
        next_cycle(); dmr = 1; redir = 1; push(STALL, 1'b1, 0, 0, 0);
        next_cycle(); rst_n = 1'b1; push(NORM, 1'b1, 0, 0, 0);
        next_cycle(); push(NORM, 1'b1, 0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
